// File: rtl/hc595_receiver.sv
// Clock-domain receiver for a 74HC595-style serial link: synchronizes ds/sh_cp/st_cp,
// shifts MSB-first on sh_cp rises and latches the word into q on st_cp rises.
module hc595_receiver #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ds,
   input  logic                          sh_cp,
   input  logic                          st_cp,
   output logic [DATA_W-1:0]             q,
   output logic                          q7s,
   output logic                          data_valid,
   output logic                          frame_err,
   output logic [$clog2(DATA_W+2)-1:0]   bit_cnt
);

   localparam int CNT_W = $clog2(DATA_W+2);
   localparam int ARM_W = $clog2(SYNC_STAGES+2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W+1);
   localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES+1);

   logic [SYNC_STAGES-1:0] r_ds_sync;
   logic [SYNC_STAGES-1:0] r_sh_sync;
   logic [SYNC_STAGES-1:0] r_st_sync;
   logic                   r_sh_dly;
   logic                   r_st_dly;
   logic [ARM_W-1:0]       r_arm_cnt;
   logic [DATA_W-1:0]      r_shreg;
   logic [DATA_W-1:0]      r_q;
   logic                   r_data_valid;
   logic                   r_frame_err;
   logic [CNT_W-1:0]       r_bit_cnt;

   logic w_ds_sync;
   logic w_sh_sync;
   logic w_st_sync;
   logic w_armed;
   logic w_sh_rise;
   logic w_st_rise;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_SAT) ? v : v + CNT_W'(1);
   endfunction

   assign w_ds_sync = r_ds_sync[SYNC_STAGES-1];
   assign w_sh_sync = r_sh_sync[SYNC_STAGES-1];
   assign w_st_sync = r_st_sync[SYNC_STAGES-1];

   // Edges stay masked until the synchronizers and delay flops have refilled after
   // reset, so an input already high at release does not look like a rising edge.
   assign w_armed   = (r_arm_cnt == ARM_DONE);
   assign w_sh_rise = w_armed & w_sh_sync & ~r_sh_dly;
   assign w_st_rise = w_armed & w_st_sync & ~r_st_dly;

   // Stage: input synchronizers and edge-detect delay flops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ds_sync <= '0;
         r_sh_sync <= '0;
         r_st_sync <= '0;
         r_sh_dly  <= 1'b0;
         r_st_dly  <= 1'b0;
         r_arm_cnt <= '0;
      end else begin
         r_ds_sync <= {r_ds_sync[SYNC_STAGES-2:0], ds};
         r_sh_sync <= {r_sh_sync[SYNC_STAGES-2:0], sh_cp};
         r_st_sync <= {r_st_sync[SYNC_STAGES-2:0], st_cp};
         r_sh_dly  <= w_sh_sync;
         r_st_dly  <= w_st_sync;
         if (!w_armed)
            r_arm_cnt <= r_arm_cnt + ARM_W'(1);
      end
   end

   // Stage: shift register, storage register and frame accounting
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shreg      <= '0;
         r_q          <= '0;
         r_data_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_bit_cnt    <= '0;
      end else begin
         r_data_valid <= w_st_rise;
         if (w_sh_rise)
            r_shreg <= {r_shreg[DATA_W-2:0], w_ds_sync};
         // A coincident shift lands after the latch: q gets pre-shift data and
         // the new frame already counts that bit.
         if (w_st_rise) begin
            r_q         <= r_shreg;
            r_frame_err <= (r_bit_cnt != CNT_FULL);
            r_bit_cnt   <= w_sh_rise ? CNT_W'(1) : '0;
         end else if (w_sh_rise) begin
            r_bit_cnt   <= sat_inc(r_bit_cnt);
         end
      end
   end

   assign q          = r_q;
   assign q7s        = r_shreg[DATA_W-1];
   assign data_valid = r_data_valid;
   assign frame_err  = r_frame_err;
   assign bit_cnt    = r_bit_cnt;

endmodule
